// File: rtl/seq_game_pkg.sv
// Shared definitions for the LED pattern player and the button sequence checker.
// Pure declarations; no logic, no latency, no flow control.
package seq_game_pkg;

    localparam int IDX_W   = 3;
    localparam int MAX_LEN = 16;
    localparam int NUM_BTN = 8;

    localparam logic [2:0] LV1 = 3'b001;
    localparam logic [2:0] LV2 = 3'b010;
    localparam logic [2:0] LV3 = 3'b100;

    localparam logic [3:0] NO_MISMATCH = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_FINISH
    } seq_state_t;

    // Zero length marks an invalid level encoding.
    function automatic logic [4:0] len_from_level(input logic [2:0] lv);
        case (lv)
            LV1:     return 5'd4;
            LV2:     return 5'd8;
            LV3:     return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] btn_to_idx(input logic [NUM_BTN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Vector debouncer: output follows the raw buttons once they hold one value for DEB_CYCLES samples.
// Latency DEB_CYCLES-1 clocks after the first sample of a new value; no backpressure.
// Any change in the raw vector restarts the stability count for the whole vector.
module button_debouncer #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb_vec
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [WIDTH-1:0] samp;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp    <= '0;
            cnt     <= CNT_W'(DEB_CYCLES);
            deb_vec <= '0;
        end else if (raw != samp) begin
            samp <= raw;
            cnt  <= CNT_W'(1);
        end else begin
            if (cnt < CNT_W'(DEB_CYCLES)) cnt <= cnt + 1'b1;
            // cnt counts matching samples already seen; this one makes DEB_CYCLES.
            if (cnt >= CNT_W'(DEB_CYCLES - 1)) deb_vec <= samp;
        end
    end

endmodule

// File: rtl/button_sequence_checker.sv
// Captures debounced button presses and compares them step by step against the shown pattern.
// done pulses 1 clk after the last release debounces; no backpressure, waits for the player.
// Optional SEQ_TIMEOUT_EN: per-step idle timeout ends the round as a loss.
module button_sequence_checker
    import seq_game_pkg::*;
#(
    parameter int DEB_CYCLES = 4
`ifdef SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 4096
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [2:0]               level,
    input  logic [MAX_LEN*IDX_W-1:0] pattern_flat,
    input  logic [NUM_BTN-1:0]       botton,
    output logic                     busy,
    output logic                     done,
    output logic                     round_win,
    output logic [3:0]               mismatch_idx,
    output logic [4:0]               step_count,
    output logic [NUM_BTN-1:0]       led_echo
);

    seq_state_t       state, state_nxt;
    logic [NUM_BTN-1:0] deb_vec, deb_prev;
    logic             enable_q;
    logic [4:0]       len, len_nxt, step_nxt;
    logic [3:0]       mismatch_nxt;
    logic             busy_nxt, done_nxt, win_nxt;
    logic             press;
    logic [IDX_W-1:0] exp_idx;

    button_debouncer #(.WIDTH(NUM_BTN), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .raw     (botton),
        .deb_vec (deb_vec)
    );

    assign led_echo = deb_vec;
    // Edge-qualified so buttons held from round start must be released first.
    assign press    = (deb_prev == '0) && (deb_vec != '0);
    assign exp_idx  = pattern_flat[step_count[3:0]*IDX_W +: IDX_W];

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    assign waiting = (state == ST_WAIT_PRESS) || (state == ST_WAIT_RELEASE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        to_cnt <= '0;
        else if (!waiting || press)      to_cnt <= '0;
        else                             to_cnt <= to_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            enable_q     <= 1'b0;
            deb_prev     <= '0;
            len          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            round_win    <= 1'b0;
            mismatch_idx <= NO_MISMATCH;
            step_count   <= '0;
        end else begin
            state        <= state_nxt;
            enable_q     <= enable;
            deb_prev     <= deb_vec;
            len          <= len_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            round_win    <= win_nxt;
            mismatch_idx <= mismatch_nxt;
            step_count   <= step_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        win_nxt      = round_win;
        mismatch_nxt = mismatch_idx;
        step_nxt     = step_count;
        case (state)
            ST_IDLE: begin
                if (enable && !enable_q && len_from_level(level) != 5'd0) begin
                    len_nxt      = len_from_level(level);
                    step_nxt     = '0;
                    mismatch_nxt = NO_MISMATCH;
                    win_nxt      = 1'b0;
                    busy_nxt     = 1'b1;
                    state_nxt    = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (press) begin
                    if (mismatch_idx == NO_MISMATCH &&
                        (!$onehot(deb_vec) || btn_to_idx(deb_vec) != exp_idx))
                        mismatch_nxt = step_count[3:0];
                    step_nxt  = step_count + 5'd1;
                    state_nxt = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (deb_vec == '0) begin
                    if (step_count == len) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        win_nxt   = (mismatch_idx == NO_MISMATCH);
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = ST_WAIT_PRESS;
                    end
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
`ifdef SEQ_TIMEOUT_EN
        if (waiting && !press && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            if (mismatch_idx == NO_MISMATCH) mismatch_nxt = step_count[3:0];
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            win_nxt   = 1'b0;
            state_nxt = ST_FINISH;
        end
`endif
    end

endmodule
